i2c_txn_arbiter: RTL

- Round-robin scheduler that shares one I2C_master command port between NUM_REQ independent requesters (e.g. CPU port, sensor poller, config loader).
- Latches the winning request's command, drives the master, tracks its busy handshake, and returns read data plus status to that requester only.
- Sits directly between the requesters and I2C_master inside the I2C top level.

---
 rtl/i2c_arb_pkg.sv | 31 +++
 rtl/i2c_txn_arbiter_if.sv | 43 ++++
 rtl/i2c_rr_picker.sv | 34 +++
 rtl/i2c_txn_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C transaction arbiter: FSM states, the fixed-depth
// byte array used on the master data bus, and the latched command record.
package i2c_arb_pkg;

  localparam int MAX_BYTES = 10;
  localparam int LEN_W     = 10;

  typedef logic [MAX_BYTES-1:0][7:0] byte_arr_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LATCH     = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    RUN       = 3'd4,
    FINISH    = 3'd5
  } arb_state_t;

  typedef struct packed {
    logic             rw;
    logic [6:0]       addr;
    logic [LEN_W-1:0] len;
    byte_arr_t        data;
  } cmd_t;

  // A transfer must move at least one byte and fit the master data bus.
  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len != 10'd0) && (len <= LEN_W'(MAX_BYTES));
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side and I2C-master-side signals of the arbiter. The slave modport
// is the arbiter's view; the master modport is the environment's view.
interface i2c_txn_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import i2c_arb_pkg::*;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_rw;
  logic [NUM_REQ-1:0][6:0]       req_addr;
  logic [NUM_REQ-1:0][LEN_W-1:0] req_len;
  byte_arr_t [NUM_REQ-1:0]       req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  byte_arr_t                     rsp_data;
  logic                          rsp_ack_err;
  logic                          rsp_tmo;
  logic                          rsp_len_err;

  logic                          m_en;
  logic [LEN_W-1:0]              m_no_of_bytes;
  logic                          m_read_write;
  logic [6:0]                    m_slave_addr;
  byte_arr_t                     m_data_in;
  byte_arr_t                     m_data_out;
  logic                          m_busy;
  logic                          m_ack_error;

  modport slave (
    input  req, req_rw, req_addr, req_len, req_data,
    input  m_data_out, m_busy, m_ack_error,
    output gnt, done, rsp_data, rsp_ack_err, rsp_tmo, rsp_len_err,
    output m_en, m_no_of_bytes, m_read_write, m_slave_addr, m_data_in
  );

  modport master (
    output req, req_rw, req_addr, req_len, req_data,
    output m_data_out, m_busy, m_ack_error,
    input  gnt, done, rsp_data, rsp_ack_err, rsp_tmo, rsp_len_err,
    input  m_en, m_no_of_bytes, m_read_write, m_slave_addr, m_data_in
  );

endinterface

// File: rtl/i2c_rr_picker.sv
// Rotating priority picker: first asserted request at or after ptr, wrapping.
module i2c_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  // Scan requesters in rotated order, keeping the first hit.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             hit;
    valid    = 1'b0;
    idx      = '0;
    cand     = 32'sd0;
    cand_idx = '0;
    hit      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(ptr) + i) % NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      hit      = req[cand_idx] && !valid;
      idx      = hit ? cand_idx : idx;
      valid    = valid || req[cand_idx];
    end
  end

  assign onehot = valid ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin scheduler sharing one I2C master command port between NUM_REQ
// requesters; the master data-bus depth is fixed by i2c_arb_pkg::MAX_BYTES.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int START_TMO = 255
) (
  input  logic              clk,
  input  logic              reset,
  i2c_txn_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(START_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(START_TMO);

  arb_state_t         state_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   win_idx_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [NUM_REQ-1:0] done_r;
  logic               m_en_r;
  cmd_t               cmd_r;
  logic [TMO_W-1:0]   tmo_cnt_r;
  byte_arr_t          rsp_data_r;
  logic               rsp_ack_err_r;
  logic               rsp_tmo_r;
  logic               rsp_len_err_r;

  logic               pick_valid_s;
  logic [NUM_REQ-1:0] pick_onehot_s;
  logic [IDX_W-1:0]   pick_idx_s;
  cmd_t               sel_cmd_s;

  i2c_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (bus.req),
    .ptr    (ptr_r),
    .valid  (pick_valid_s),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s)
  );

  // Command fields of the requester chosen in IDLE.
  always_comb begin
    sel_cmd_s.rw   = bus.req_rw[win_idx_r];
    sel_cmd_s.addr = bus.req_addr[win_idx_r];
    sel_cmd_s.len  = bus.req_len[win_idx_r];
    sel_cmd_s.data = bus.req_data[win_idx_r];
  end

  // Transaction FSM; every output comes straight from a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      ptr_r         <= '0;
      win_idx_r     <= '0;
      gnt_r         <= '0;
      done_r        <= '0;
      m_en_r        <= 1'b0;
      cmd_r         <= '0;
      tmo_cnt_r     <= '0;
      rsp_data_r    <= '0;
      rsp_ack_err_r <= 1'b0;
      rsp_tmo_r     <= 1'b0;
      rsp_len_err_r <= 1'b0;
    end else begin
      done_r <= '0;
      m_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // A busy master here means another bus owner; do not start.
          if (pick_valid_s && !bus.m_busy) begin
            win_idx_r <= pick_idx_s;
            gnt_r     <= pick_onehot_s;
            state_r   <= LATCH;
          end
        end
        LATCH: begin
          cmd_r <= sel_cmd_s;
          ptr_r <= (win_idx_r == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_r + IDX_W'(1);
          if (len_legal(sel_cmd_s.len)) begin
            m_en_r  <= 1'b1;
            state_r <= START;
          end else begin
            rsp_len_err_r <= 1'b1;
            rsp_tmo_r     <= 1'b0;
            rsp_ack_err_r <= 1'b0;
            done_r        <= gnt_r;
            state_r       <= FINISH;
          end
        end
        START: begin
          tmo_cnt_r <= '0;
          state_r   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.m_busy) begin
            state_r <= RUN;
          end else if (tmo_cnt_r + TMO_W'(1) == TMO_LIMIT) begin
            rsp_tmo_r     <= 1'b1;
            rsp_ack_err_r <= 1'b0;
            rsp_len_err_r <= 1'b0;
            done_r        <= gnt_r;
            state_r       <= FINISH;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        RUN: begin
          // ack_error is only meaningful at the falling edge of busy.
          if (!bus.m_busy) begin
            if (cmd_r.rw) begin
              rsp_data_r <= bus.m_data_out;
            end
            rsp_ack_err_r <= bus.m_ack_error;
            rsp_tmo_r     <= 1'b0;
            rsp_len_err_r <= 1'b0;
            done_r        <= gnt_r;
            state_r       <= FINISH;
          end
        end
        FINISH: begin
          gnt_r   <= '0;
          state_r <= IDLE;
        end
        default: begin
          gnt_r   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt           = gnt_r;
  assign bus.done          = done_r;
  assign bus.rsp_data      = rsp_data_r;
  assign bus.rsp_ack_err   = rsp_ack_err_r;
  assign bus.rsp_tmo       = rsp_tmo_r;
  assign bus.rsp_len_err   = rsp_len_err_r;
  assign bus.m_en          = m_en_r;
  assign bus.m_no_of_bytes = cmd_r.len;
  assign bus.m_read_write  = cmd_r.rw;
  assign bus.m_slave_addr  = cmd_r.addr;
  assign bus.m_data_in     = cmd_r.data;

endmodule
